// File: rtl/div2_engine.sv
// Program-2 reference divider: reads a 16-bit dividend and an 8-bit divisor from data bytes 0-2
// and writes the 24-bit quotient (16.8 fixed point) to bytes 4-6. Define DIV2_ROUND_EN for half-LSB rounding.
module div2_engine #(
  parameter int DIV_ITERS = 24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  input  logic [7:0] MemRdData,
  output logic [7:0] MemWrData,
  output logic       MemWrEn,
  output logic [3:0] dbg_state
);

`ifdef DIV2_ROUND_EN
  localparam int ITERS = 25;
`else
  localparam int ITERS = DIV_ITERS;
`endif
  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_DIV, S_WR0, S_WR1, S_WR2, S_DONE
  } state_t;

  state_t           state;
  logic             start_q;
  logic [15:0]      dividend;
  logic [7:0]       divisor;
  logic [ITERS-1:0] num;
  logic [7:0]       rem;
  logic [4:0]       iter_cnt;
  logic [15:0]      q_tail;

  logic [8:0]       rem_shift;
  logic             take;
  logic [7:0]       rem_next;
  logic [ITERS-1:0] num_next;
  logic [23:0]      result;

  assign dbg_state = state;

  // num shifts the numerator out of its MSB while quotient bits enter at its LSB,
  // so after the last iteration it holds the raw quotient.
  always_comb begin
    rem_shift = {rem, num[ITERS-1]};
    take      = rem_shift >= {1'b0, divisor};
    // When take is set the true difference is below the divisor, so 8-bit wraparound is exact.
    rem_next  = take ? (rem_shift[7:0] - divisor) : rem_shift[7:0];
    num_next  = {num[ITERS-2:0], take};
`ifdef DIV2_ROUND_EN
    result    = num_next[24:1] + {23'd0, num_next[0]};
`else
    result    = num_next[23:0];
`endif
  end

  // Handshake: Start is a level; a run launches when IDLE sees Start 1 on one edge and 0 on the
  // next. Ack rises after the third result write and holds until Start is seen high in DONE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      Ack       <= 1'b0;
      MemAddr   <= 8'd0;
      MemWrData <= 8'd0;
      MemWrEn   <= 1'b0;
      dividend  <= 16'd0;
      divisor   <= 8'd0;
      num       <= '0;
      rem       <= 8'd0;
      iter_cnt  <= 5'd0;
      q_tail    <= 16'd0;
    end else begin
      start_q <= Start;
      case (state)
        S_IDLE: begin
          if (start_q && !Start) begin
            MemAddr <= 8'd0;
            state   <= S_RD0;
          end
        end
        S_RD0: begin
          dividend[15:8] <= MemRdData;
          MemAddr        <= 8'd1;
          state          <= S_RD1;
        end
        S_RD1: begin
          dividend[7:0] <= MemRdData;
          MemAddr       <= 8'd2;
          state         <= S_RD2;
        end
        S_RD2: begin
          divisor <= MemRdData;
          if (MemRdData == 8'd0) begin
            q_tail    <= 16'hFFFF;
            MemWrEn   <= 1'b1;
            MemAddr   <= 8'd4;
            MemWrData <= 8'hFF;
            state     <= S_WR0;
          end else begin
            num      <= {dividend, {(ITERS-16){1'b0}}};
            rem      <= 8'd0;
            iter_cnt <= 5'd0;
            MemAddr  <= 8'd0;
            state    <= S_DIV;
          end
        end
        S_DIV: begin
          num      <= num_next;
          rem      <= rem_next;
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == LAST_ITER) begin
            q_tail    <= result[15:0];
            MemWrEn   <= 1'b1;
            MemAddr   <= 8'd4;
            MemWrData <= result[23:16];
            state     <= S_WR0;
          end
        end
        S_WR0: begin
          MemAddr   <= 8'd5;
          MemWrData <= q_tail[15:8];
          state     <= S_WR1;
        end
        S_WR1: begin
          MemAddr   <= 8'd6;
          MemWrData <= q_tail[7:0];
          state     <= S_WR2;
        end
        S_WR2: begin
          MemWrEn   <= 1'b0;
          MemAddr   <= 8'd0;
          MemWrData <= 8'd0;
          Ack       <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (Start) begin
            Ack   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div2_engine.md
# div2_engine

Fixed-function sequential divider for program 2: 16-bit dividend ÷ 8-bit divisor → 24-bit quotient (16 integer + 8 fraction bits). It shares the data-memory port and the Start/Ack handshake with the CPU core. It pulls operands from data memory bytes 0–2 and writes the result to bytes 4–6. The program-2 bench drives it exactly as it drives the CPU, and its result is the reference against which the CPU's software divide is compared.

## Interface
- `DIV_ITERS`, default 24: quotient bits produced; forced to 25 when `DIV2_ROUND_EN` is defined.
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  launch request; level signal, program launches on its 1→0 transition.
- `Ack`  out  1  run complete; held until next launch.
- `MemAddr`  out  8  data-memory byte address.
- `MemRdData`  in  8  data-memory read data; combinational, valid same cycle as `MemAddr`.
- `MemWrData`  out  8  data-memory write data.
- `MemWrEn`  out  1  write strobe; memory writes on the rising `Clk`.

## Operation
- Reset (`Reset`=0) values:
  - State IDLE.
  - `Ack`=0, `MemWrEn`=0, `MemAddr`=0, `MemWrData`=0.
  - All datapath registers 0.
- **IDLE**
  - Register the sampled `Start`.
  - On `Start` seen 1 then 0, go to RD0.
- **RD0/RD1/RD2**
  - `MemAddr`=0,1,2 in turn.
  - Latch dividend[15:8], dividend[7:0], divisor.
- After RD2:
  - Divisor==0: load Q=24'hFFFFFF and go to WR0 (saturate).
  - Otherwise go to DIV.
- **DIV**: restoring divide, one quotient bit per cycle, MSB first.
  - Numerator N = {dividend, 8'h00}, 24 bits.
  - 9-bit remainder R: R' = {R[7:0], N[msb]}.
  - If R' ≥ divisor: subtract divisor, shift in quotient bit 1; else shift in 0.
  - Iteration counter counts `DIV_ITERS` cycles, then go to WR0.
- **Quotient result**: Q = floor((dividend·256)/divisor).
  - Never exceeds 24 bits (max 0xFFFF00 at divisor 1).
- **WR0/WR1/WR2**
  - `MemWrEn`=1; `MemAddr`=4,5,6.
  - `MemWrData`=Q[23:16], Q[15:8], Q[7:0].
- **DONE**
  - `Ack`=1; memory port idle (`MemWrEn`=0).
  - On `Start`=1, drop `Ack` and return to IDLE; a new 1→0 then relaunches.
- `Start` activity in RD/DIV/WR states is ignored; operation continues.
- Bytes 3 and ≥7 are never written.

## Timing
- Cycle 0 = first rising edge where IDLE samples `Start`=0 after 1.
- Cycles 1–3: RD0–RD2.
- Cycles 4–27: DIV, 24 cycles (25 with rounding: cycles 4–28).
- Cycles 28–30: WR0–WR2, i.e. three memory writes.
- `Ack` rises at cycle 31 (32 with rounding).
- Zero divisor skips DIV: writes in cycles 4–6, `Ack` at cycle 7.
- `Ack` falls the cycle after `Start` is sampled 1 in DONE.
- Reset asserted mid-run:
  - Immediate return to IDLE with all outputs at reset values.
  - Partially written result bytes stay in memory.
  - No further writes until the next launch.
- `Start` already 0 when reset releases: no launch; a 1→0 edge is required.

## Configuration
- `DIV2_ROUND_EN` defined:
  - 25 DIV iterations produce Q25.
  - Result = Q25[24:1] + Q25[0] (half-LSB upward rounding).
  - Cannot overflow: max Q25 for divisor ≥ 2 is below 2^24.
  - Zero divisor still gives 0xFFFFFF.
- Undefined: 24 iterations, truncated quotient (bench default, no rounding).

## Test plan
- Dividend 0x0003, divisor 0xFF, Start held 1 then dropped → bytes 4–6 = 00 00 03, `Ack` at cycle 31, then match against bench model.
- Dividend 0x0002, divisor 0x03 → 00 00 AA without `DIV2_ROUND_EN`; 00 00 AB with it, `Ack` at cycle 32.
- Dividend 0xFFFF, divisor 0x01 → FF FF 00; dividend 0x0000, divisor 0x07 → 00 00 00.
- Dividend 0x1234, divisor 0x00 → FF FF FF, `Ack` at cycle 7, DIV never entered.
- `Reset` pulsed low at cycle 15 → `Ack`=0 and `MemWrEn`=0 immediately, no writes to bytes 4–6. Then Start 1→0 with 0x0001/0x03 → 00 00 55.
- Back-to-back runs, toggling `Start` 1 for 2 cycles between them:
  - First `Ack` drops one cycle after `Start` rises.
  - Second result overwrites bytes 4–6 correctly.
  - Byte 3 unchanged throughout.
